bcd_display_scanner: RTL and testbench

//  Downstream consumer of the BCD counters. Takes NUM_DIGITS packed 4-bit BCD digits and

---
 rtl/bcd_disp_pkg.sv | 19 +
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_display_scanner.sv | 88 ++++++++
 tb/tb_bcd_display_scanner.sv | 88 ++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD digit type, active-low {g,f,e,d,c,b,a} segment patterns, validity helper
package bcd_disp_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  function automatic logic bcd_is_valid(bcd_t d);
    return d < 4'd10;
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit -> active-low 7-segment pattern; codes 10-15 show a dash
//   digit_i  in  4  BCD code
//   seg_n_o  out 7  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_n_o
);
  always_comb begin
    seg_n_o = SEG_DASH;
    if (bcd_is_valid(digit_i))
      case (digit_i)
        4'd0:    seg_n_o = SEG_0;
        4'd1:    seg_n_o = SEG_1;
        4'd2:    seg_n_o = SEG_2;
        4'd3:    seg_n_o = SEG_3;
        4'd4:    seg_n_o = SEG_4;
        4'd5:    seg_n_o = SEG_5;
        4'd6:    seg_n_o = SEG_6;
        4'd7:    seg_n_o = SEG_7;
        4'd8:    seg_n_o = SEG_8;
        4'd9:    seg_n_o = SEG_9;
        default: seg_n_o = SEG_DASH;
      endcase
  end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed common-anode 7-segment scanner with shadow-registered digits
//   clk, rst (sync, active-high); digits_in/dp_in/load capture into pending register;
//   seg_n/dp_n/an_n active-low registered display drive; frame_done pulses when the last slot ends.
//   Optional leading-zero blanking: define BCD_SCAN_LZB_EN.
module bcd_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);
  import bcd_disp_pkg::*;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  logic [PW-1:0]           pre_q;
  logic [IW-1:0]           idx_q;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, disp_dig_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q, an_q;
  logic [6:0]              seg_q, dec_seg;
  logic                    dp_q, fd_q, wrap, frame_end, blank, lzb;
  bcd_t                    cur_dig;
  assign wrap = pre_q == PRE_LAST;
  assign frame_end = wrap && idx_q == IDX_LAST;
  assign blank = pre_q < PRE_BLANK;
  assign cur_dig = disp_dig_q[idx_q*4 +: 4];
  bcd_to_seg7 u_dec (.digit_i(cur_dig), .seg_n_o(dec_seg));
`ifdef BCD_SCAN_LZB_EN
  // hz[i] = digit i and every higher digit are zero; digit 0 is never blanked.
  logic [NUM_DIGITS-1:0] hz;
  always_comb begin
    logic acc;
    acc = 1'b1;
    hz = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc = acc & (disp_dig_q[i*4 +: 4] == 4'd0);
      hz[i] = acc;
    end
  end
  assign lzb = idx_q != '0 && hz[idx_q];
`else
  assign lzb = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      pre_q <= wrap ? '0 : pre_q + 1'b1;
      if (wrap) idx_q <= frame_end ? '0 : idx_q + 1'b1;
      if (load) begin
        pend_dig_q <= digits_in;
        pend_dp_q  <= dp_in;
      end
      // display takes the pre-edge pending value, so a coincident load lands one frame later
      if (frame_end) begin
        disp_dig_q <= pend_dig_q;
        disp_dp_q  <= pend_dp_q;
      end
      fd_q  <= frame_end;
      an_q  <= blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      seg_q <= (blank || lzb) ? SEG_OFF : dec_seg;
      dp_q  <= blank ? 1'b1 : ~disp_dp_q[idx_q];
    end
  end
  assign seg_n = seg_q;
  assign dp_n = dp_q;
  assign an_n = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed + random stimulus checked against a cycle-count arithmetic model
module tb_bcd_display_scanner;
  localparam int ND = 4, DIV = 6, BLK = 2, FRAME = ND * DIV;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0, an_n;
  logic [6:0]  seg_n;
  logic        dp_n, frame_done;
  int          compared = 0, mismatched = 0, tt = 0;
  logic [15:0] pend = '0, disp = '0;
  logic [3:0]  pdp = '0, ddp = '0;
  logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  bcd_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, tt, obs, exp);
    end
  endtask
  // tt counts clock edges since reset release; the outputs seen after an edge describe the
  // state before it: slot = tt/DIV, phase = tt%DIV, frame = tt/FRAME.
  task automatic step(input logic r, input logic ld, input logic [15:0] d, input logic [3:0] p);
    logic [6:0] e_seg;
    logic [3:0] e_an, v;
    logic       e_dp, e_fd;
    int         pre, idx;
    @(negedge clk);
    rst = r; load = ld; digits_in = d; dp_in = p;
    e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
    if (r) begin
      tt = 0; pend = '0; pdp = '0; disp = '0; ddp = '0;
    end else begin
      pre = tt % DIV;
      idx = (tt / DIV) % ND;
      v = 4'((disp >> (idx * 4)) & 16'hF);
      e_fd = (tt % FRAME) == FRAME - 1;
      if (pre >= BLK) begin
        e_an = ~(4'b0001 << idx);
        e_seg = tbl[v];
        e_dp = ~ddp[idx];
`ifdef BCD_SCAN_LZB_EN
        if (idx != 0 && (disp >> (idx * 4)) == 16'd0) e_seg = 7'h7F;
`endif
      end
      if (e_fd) begin disp = pend; ddp = pdp; end
      if (ld) begin pend = d; pdp = p; end
      tt++;
    end
    @(posedge clk);
    #1;
    chk("an_n", {4'h0, an_n}, {4'h0, e_an});
    chk("seg_n", {1'b0, seg_n}, {1'b0, e_seg});
    chk("dp_n", {7'h0, dp_n}, {7'h0, e_dp});
    chk("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask
  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(30);
    step(1'b0, 1'b1, 16'h1234, 4'b0100);
    idle(60);
    step(1'b0, 1'b1, 16'h0007, 4'b0000);
    idle(50);
    step(1'b0, 1'b1, 16'hA5F9, 4'b1001);
    idle(50);
    while (tt % FRAME != FRAME - 1) idle(1);
    step(1'b0, 1'b1, 16'h1111, 4'b0001);
    idle(50);
    while (tt % FRAME != 2 * DIV + 3) idle(1);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(30);
    step(1'b0, 1'b1, 16'h0090, 4'b0011);
    step(1'b0, 1'b1, 16'h0305, 4'b1000);
    idle(40);
    for (int i = 0; i < 500; i++)
      step(($urandom % 150) == 0, ($urandom % 6) == 0, 16'($urandom), 4'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
